// File: rtl/data_ram_responder_pkg.sv
// Shared LSU write-mask codes and the helper that folds unsupported masks onto
// the word encoding.
package data_ram_responder_pkg;

    localparam logic [3:0] WEN_NONE = 4'b0000;
    localparam logic [3:0] WEN_BYTE = 4'b0001;
    localparam logic [3:0] WEN_HALF = 4'b0011;
    localparam logic [3:0] WEN_WORD = 4'b1111;

    // Any mask the LSU should never produce behaves as a full-word store.
    function automatic logic [3:0] norm_wen(input logic [3:0] w);
        case (w)
            WEN_NONE, WEN_BYTE, WEN_HALF, WEN_WORD: return w;
            default:                                return WEN_WORD;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_responder_byte_lane_ram.sv
// Four byte-wide synchronous arrays sharing one index, each with its own write
// enable. The read port is registered and read-first.
module byte_lane_ram #(
    parameter int ADDR_W    = 12,
    parameter int INIT_ZERO = 0
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        if (INIT_ZERO != 0) begin : g_zero
            logic [7:0] mem [DEPTH] = '{default: 8'h00};
            always_ff @(posedge clk) begin
                if (en) rdata[8*i +: 8] <= mem[idx];
                if (we[i]) mem[idx] <= wdata[8*i +: 8];
            end
        end else begin : g_undef
            logic [7:0] mem [DEPTH];
            always_ff @(posedge clk) begin
                if (en) rdata[8*i +: 8] <= mem[idx];
                if (we[i]) mem[idx] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_ram_responder.sv
// Data RAM responder beneath the LSU: byte-lane steering, masked stores,
// misalignment flag, right-justified load data one cycle after the request.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int INIT_ZERO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ram_en,
    input  logic [3:0]  data_ram_wen,
    input  logic [31:0] data_ram_addr,
    input  logic [31:0] data_ram_wdata,
    output logic [31:0] data_ram_rdata,
    output logic        data_ram_err
);

    logic [1:0]  off, off_q;
    logic [3:0]  wen_n, lanes, we;
    logic        mis, rd_zero_q;
    logic [31:0] ram_q;
    logic        unused_addr;

    assign unused_addr = ^data_ram_addr[31:ADDR_W+2];

    assign off   = data_ram_addr[1:0];
    assign wen_n = norm_wen(data_ram_wen);
    assign lanes = wen_n << off;
    assign mis   = data_ram_en &&
                   ((wen_n == WEN_HALF && off[0]) || (wen_n == WEN_WORD && off != 2'd0));
    // Stores are dropped when misaligned and while reset is held.
    assign we    = lanes & {4{data_ram_en && !rst && !mis}};

    byte_lane_ram #(.ADDR_W(ADDR_W), .INIT_ZERO(INIT_ZERO)) u_ram (
        .clk   (clk),
        .en    (data_ram_en),
        .we    (we),
        .idx   (data_ram_addr[ADDR_W+1:2]),
        .wdata (data_ram_wdata),
        .rdata (ram_q)
    );

    // The RAM output register has no reset; rd_zero_q forces zeros until the
    // first access after reset refreshes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            off_q        <= 2'd0;
            data_ram_err <= 1'b0;
            rd_zero_q    <= 1'b1;
        end else if (data_ram_en) begin
            off_q        <= off;
            data_ram_err <= mis;
            rd_zero_q    <= 1'b0;
        end
    end

    assign data_ram_rdata = rd_zero_q ? 32'h0 : (ram_q >> {off_q, 3'b000});

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder: a vector table for steady-state
// accesses plus hand sequences around reset.
module tb_data_ram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_ram_responder #(.ADDR_W(8), .INIT_ZERO(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_ram_en    (en),
        .data_ram_wen   (wen),
        .data_ram_addr  (addr),
        .data_ram_wdata (wdata),
        .data_ram_rdata (rdata),
        .data_ram_err   (err)
    );

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%08h want=%08h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d);
        en = e; wen = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;

        // Load requested while in reset: reset wins.
        #1;
        step(1'b1, 4'b0000, 32'h10, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        rst = 1'b0;
        step(1'b0, 4'b0000, 32'h0, 32'h0);
        chk("post_rst_idle_rdata", rdata, 32'h0);

        //            en  wen      addr    wdata         rdata         err
        vecs.push_back('{1, 4'b0000, 32'h10, 32'h00000000, 32'h00000000, 0});
        vecs.push_back('{1, 4'b1111, 32'h20, 32'hDEADBEEF, 32'h00000000, 0});
        vecs.push_back('{1, 4'b0000, 32'h20, 32'h00000000, 32'hDEADBEEF, 0});
        vecs.push_back('{1, 4'b0000, 32'h21, 32'h00000000, 32'h00DEADBE, 0});
        vecs.push_back('{1, 4'b0000, 32'h22, 32'h00000000, 32'h0000DEAD, 0});
        vecs.push_back('{1, 4'b0000, 32'h23, 32'h00000000, 32'h000000DE, 0});
        vecs.push_back('{1, 4'b0001, 32'h23, 32'h5A5A5A5A, 32'h000000DE, 0});
        vecs.push_back('{1, 4'b0011, 32'h20, 32'h12341234, 32'h5AADBEEF, 0});
        vecs.push_back('{1, 4'b0000, 32'h20, 32'h00000000, 32'h5AAD1234, 0});
        vecs.push_back('{1, 4'b0011, 32'h21, 32'hFFFFFFFF, 32'h005AAD12, 1});
        vecs.push_back('{1, 4'b1111, 32'h22, 32'hFFFFFFFF, 32'h00005AAD, 1});
        vecs.push_back('{0, 4'b0000, 32'h20, 32'h00000000, 32'h00005AAD, 1});
        vecs.push_back('{1, 4'b0000, 32'h20, 32'h00000000, 32'h5AAD1234, 0});
        vecs.push_back('{0, 4'b1111, 32'h20, 32'hFFFFFFFF, 32'h5AAD1234, 0});
        vecs.push_back('{1, 4'b0000, 32'h20, 32'h00000000, 32'h5AAD1234, 0});
        vecs.push_back('{1, 4'b1111, 32'h40, 32'h11223344, 32'h00000000, 0});
        vecs.push_back('{1, 4'b0000, 32'h40, 32'h00000000, 32'h11223344, 0});
        vecs.push_back('{1, 4'b0011, 32'h42, 32'h55665566, 32'h00001122, 0});
        vecs.push_back('{1, 4'b0000, 32'h40, 32'h00000000, 32'h55663344, 0});
        vecs.push_back('{1, 4'b1111, 32'h44, 32'hAABBCCDD, 32'h00000000, 0});
        vecs.push_back('{1, 4'b0000, 32'h44, 32'h00000000, 32'hAABBCCDD, 0});
        vecs.push_back('{1, 4'b0001, 32'h45, 32'h77777777, 32'h00AABBCC, 0});
        vecs.push_back('{1, 4'b0000, 32'h44, 32'h00000000, 32'hAABB77DD, 0});
        vecs.push_back('{1, 4'b0101, 32'h44, 32'h01020304, 32'hAABB77DD, 0});
        vecs.push_back('{1, 4'b0000, 32'h44, 32'h00000000, 32'h01020304, 0});
        vecs.push_back('{1, 4'b0101, 32'h46, 32'hFFFFFFFF, 32'h00000102, 1});
        vecs.push_back('{1, 4'b0000, 32'h44, 32'h00000000, 32'h01020304, 0});
        vecs.push_back('{1, 4'b1111, 32'h60, 32'h0A0B0C0D, 32'h00000000, 0});
        vecs.push_back('{1, 4'b0000, 32'h60, 32'h00000000, 32'h0A0B0C0D, 0});

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
        end

        // Misaligned half sets err, then reset arrives together with a store.
        step(1'b1, 4'b0011, 32'h61, 32'hFFFFFFFF);
        chk("pre_rst_rdata", rdata, 32'h000A0B0C);
        chk("pre_rst_err", {31'h0, err}, 32'h1);
        rst = 1'b1;
        step(1'b1, 4'b1111, 32'h60, 32'hFFFFFFFF);
        chk("rst_sw_rdata", rdata, 32'h0);
        chk("rst_sw_err", {31'h0, err}, 32'h0);
        rst = 1'b0;
        step(1'b0, 4'b0000, 32'h0, 32'h0);
        chk("after_rst_rdata", rdata, 32'h0);
        chk("after_rst_err", {31'h0, err}, 32'h0);
        step(1'b1, 4'b0000, 32'h60, 32'h0);
        chk("rst_sw_dropped", rdata, 32'h0A0B0C0D);
        step(1'b1, 4'b0000, 32'h63, 32'h0);
        chk("after_rst_off3", rdata, 32'h0000000A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

Memory-side responder for the load/store unit's data RAM port. It consumes `data_ram_en`/`wen`/`addr`/`wdata` in the EX stage and returns `data_ram_rdata` one cycle later, in the MEM stage. It steers byte lanes by address offset, performs byte-masked writes into an on-chip word array, and flags misaligned accesses. It sits directly beneath the LSU and replaces a behavioural RAM model in the core's top level.

## Interface
- `ADDR_W`, 12: word-index width; array depth is 2^ADDR_W 32-bit words (16 KiB at default).
- `INIT_ZERO`, 0: 1 zero-fills the array at elaboration (simulation only); 0 leaves contents undefined.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `data_ram_en`  in  1  access request this cycle.
- `data_ram_wen`  in  4  lane-0-justified write mask from LSU: 0001 byte, 0011 half, 1111 word, 0000 load.
- `data_ram_addr`  in  32  byte address; bits [ADDR_W+1:2] index the array, upper bits ignored.
- `data_ram_wdata`  in  32  store data, already replicated across lanes by the LSU.
- `data_ram_rdata`  out  32  load data, right-justified (addressed byte/half in bits [7:0]/[15:0]).
- `data_ram_err`  out  1  misaligned access flag, valid in the same cycle as `data_ram_rdata`.

## Operation
- Offset `off = addr[1:0]`. Effective lane mask `lanes = wen << off`, truncated to 4 bits.
- Misaligned when `en` and any of the following holds:
  - `wen==0011` and `off[0]==1`;
  - `wen==1111` and `off!=0`;
  - load alignment is not checkable (no size input), so loads are never flagged.
- Misaligned stores are suppressed (no lane written).
- Store (`en` and `wen!=0`, aligned): each lane i with `lanes[i]==1` takes `wdata[8i+7:8i]` at the clock edge; other lanes are unchanged.
- Read is read-first. On any `en` cycle the array word at the index is read before that edge's write. `rdata` next cycle = `old_word >> (8*off)`, zero-filled in the upper bits.
- No `en`: array unchanged; `rdata` and `err` hold their previous values.
- `wen` values other than 0000/0001/0011/1111 are treated as 1111 for alignment and lanes. This is a verification assertion, not a supported mode.
- Reset does not clear the array.

## Timing
- Reset values: `data_ram_rdata = 32'h0`, `data_ram_err = 0`. The latched offset is 0.
- Read latency is exactly 1 cycle: an `en` at cycle N produces `rdata`/`err` valid from N+1 until the next `en` edge.
- Write takes effect at the edge ending cycle N. A load to the same word at N+1 returns the new data; there is no bypass path and none is needed.
- `rst` asserted together with `en`: reset wins for `rdata`/`err`. The array write at that edge is still suppressed, so no store commits during reset.
- `rst` mid-stream: the cycle after deassertion behaves like the first cycle after reset. There is no pending state to recover.
- Back-to-back `en` every cycle is fully supported; the responder never stalls.

## Structure
- Shared package/defines header (alongside the LSU select codes): `WEN_BYTE=4'b0001`, `WEN_HALF=4'b0011`, `WEN_WORD=4'b1111`, `WEN_NONE=4'b0000`.
- Sub-module `byte_lane_ram`: four 8-bit-wide, 2^ADDR_W-deep synchronous arrays with per-lane write enable and a registered read port. It maps to block RAM.
- The top level holds the lane shift, the alignment check, the offset register (2 bits) for the read shift, and the `err` register.

## Test plan
- Reset, then load from addr 0x10 → `rdata==0` during reset; after reset with `INIT_ZERO=1`, `rdata==0`, `err==0`.
- SW 0xDEADBEEF @0x20, then load @0x20/@0x21/@0x22/@0x23 → `rdata` = 0xDEADBEEF, 0x00DEADBE, 0x0000DEAD, 0x000000DE.
- Over the word from the previous test: SB wdata 0x5A5A5A5A @0x23, then SH wdata 0x12341234 @0x20, then load @0x20 → 0x5AAD1234.
- SH @0x21 and SW @0x22 → `err==1` on the following cycle, and a later load @0x20 is unchanged.
- Store @0x40 at cycle N, load @0x40 at N+1 → new data at N+2. Load and store @0x44 in the same cycle → old data returned.
- `rst` asserted in the same cycle as SW @0x60 → `rdata==0`, `err==0`, and a later load @0x60 shows the pre-reset value.
